// File: rtl/mem_load_unit.sv
// MEM-stage load controller: issues a data-memory read for the load in EX/MEM,
// stalls the pipeline while it is outstanding and returns the extended result.
module mem_load_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead_EXMEM,
    input  logic [31:0] Instruction_EXMEM,
    input  logic [31:0] addr_EXMEM,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall_MEM,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        load_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_e;

    state_e             state_q;
    logic [31:0]        addr_q;
    logic [2:0]         f3_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [31:0]        load_data_q;

    logic [2:0]         f3_in;
    logic               misaligned_c;
    logic               new_load_c;
    logic               wait_max_c;
    logic               unused_instr_c;

    assign f3_in          = Instruction_EXMEM[14:12];
    assign unused_instr_c = ^{Instruction_EXMEM[31:15], Instruction_EXMEM[11:0]};
    assign new_load_c     = (state_q == IDLE) && memRead_EXMEM && !flush;
    assign wait_max_c     = (wait_cnt_q == CNT_W'(MAX_WAIT));

    // Byte loads are never misaligned; unknown funct3 behaves as LW.
    always_comb begin
        misaligned_c = 1'b0;
        case (f3_in)
            3'b000, 3'b100: misaligned_c = 1'b0;
            3'b001, 3'b101: misaligned_c = addr_EXMEM[0];
            default:        misaligned_c = (addr_EXMEM[1:0] != 2'b00);
        endcase
    end

    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  lane,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b100:  extract = {24'b0, b};
            3'b101:  extract = {16'b0, h};
            default: extract = word;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            f3_q        <= '0;
            wait_cnt_q  <= '0;
            load_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (new_load_c) begin
                        if (misaligned_c) begin
                            load_data_q <= '0;
                        end else begin
                            addr_q     <= addr_EXMEM;
                            f3_q       <= f3_in;
                            wait_cnt_q <= '0;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_rvalid) begin
                        load_data_q <= extract(f3_q, addr_q[1:0], mem_rdata);
                        state_q     <= DONE;
                    end else if (flush) begin
                        wait_cnt_q <= '0;
                        state_q    <= DRAIN;
                    end else if (wait_max_c) begin
                        load_data_q <= '0;
                        wait_cnt_q  <= '0;
                        state_q     <= DRAIN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                DONE: state_q <= IDLE;
                // Swallow the late response of an abandoned request.
                DRAIN: begin
                    if (mem_rvalid || wait_max_c) begin
                        state_q <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req    = (state_q == REQ);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign stall_MEM  = (new_load_c && !misaligned_c) || (state_q == REQ) || (state_q == DRAIN);
    assign load_valid = (state_q == DONE) && !flush;
    assign load_data  = load_data_q;
    assign load_err   = (new_load_c && misaligned_c) ||
                        ((state_q == REQ) && !mem_rvalid && !flush && wait_max_c);

endmodule

// File: tb/tb_mem_load_unit.sv
// Randomized bench for mem_load_unit against a transaction-level load model.
module tb_mem_load_unit;

    localparam int unsigned MAXW = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead_EXMEM;
    logic [31:0] Instruction_EXMEM;
    logic [31:0] addr_EXMEM;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_MEM;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data = 32'h0;

    mem_load_unit #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .memRead_EXMEM(memRead_EXMEM),
        .Instruction_EXMEM(Instruction_EXMEM), .addr_EXMEM(addr_EXMEM),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall_MEM(stall_MEM),
        .load_valid(load_valid), .load_data(load_data), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return addr[0];
        return addr[1:0] != 2'b00;
    endfunction

    // delay: REQ cycle index carrying rvalid (> MAXW means never); flush_at: REQ index or -1.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                            input int delay, input int flush_at, input bit flush_done);
        bit hit, fl, stop;
        int n;
        logic [31:0] exp;
        next_cycle();
        memRead_EXMEM     = 1'b1;
        Instruction_EXMEM = {17'($urandom), f3, 12'($urandom)};
        addr_EXMEM        = addr;
        flush             = 1'b0;
        mem_rvalid        = 1'b0;
        sample();
        if (ref_misaligned(f3, addr)) begin
            check("mis_err", 32'(load_err), 32'd1);
            check("mis_stall", 32'(stall_MEM), 32'd0);
            check("mis_req", 32'(mem_req), 32'd0);
            next_cycle();
            memRead_EXMEM = 1'b0;
            sample();
            check("mis_data", load_data, 32'd0);
            check("mis_req_after", 32'(mem_req), 32'd0);
            check("mis_err_after", 32'(load_err), 32'd0);
            last_data = 32'd0;
            return;
        end
        check("stall_N", 32'(stall_MEM), 32'd1);
        check("err_N", 32'(load_err), 32'd0);
        stop = 1'b0;
        for (int k = 0; k <= int'(MAXW) && !stop; k++) begin
            next_cycle();
            hit        = (k == delay);
            fl         = (k == flush_at) && !hit;
            mem_rvalid = hit;
            mem_rdata  = hit ? rdata : $urandom;
            flush      = fl;
            if (fl) memRead_EXMEM = 1'b0;
            sample();
            check("req_high", 32'(mem_req), 32'd1);
            check("req_addr", mem_addr, addr & ~32'h3);
            check("req_stall", 32'(stall_MEM), 32'd1);
            check("req_valid", 32'(load_valid), 32'd0);
            check("req_err", 32'(load_err), 32'(!hit && !fl && k == int'(MAXW)));
            if (hit) begin
                exp = ref_load(f3, addr, rdata);
                next_cycle();
                mem_rvalid = 1'b0;
                flush      = flush_done;
                sample();
                check("done_valid", 32'(load_valid), 32'(!flush_done));
                check("done_stall", 32'(stall_MEM), 32'd0);
                check("done_req", 32'(mem_req), 32'd0);
                check("done_data", load_data, exp);
                last_data = exp;
                next_cycle();
                memRead_EXMEM = 1'b0;
                flush         = 1'b0;
                sample();
                check("post_valid", 32'(load_valid), 32'd0);
                stop = 1'b1;
            end else if (fl) begin
                next_cycle();
                flush = 1'b0;
                sample();
                check("drain_req", 32'(mem_req), 32'd0);
                check("drain_stall", 32'(stall_MEM), 32'd1);
                next_cycle();
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
                sample();
                check("drain_stall2", 32'(stall_MEM), 32'd1);
                next_cycle();
                mem_rvalid = 1'b0;
                sample();
                check("flush_stall", 32'(stall_MEM), 32'd0);
                check("flush_valid", 32'(load_valid), 32'd0);
                check("flush_data", load_data, last_data);
                stop = 1'b1;
            end else if (k == int'(MAXW)) begin
                next_cycle();
                memRead_EXMEM = 1'b0;
                sample();
                check("to_req", 32'(mem_req), 32'd0);
                check("to_err_after", 32'(load_err), 32'd0);
                n = 1;
                while (stall_MEM && n < 50) begin
                    next_cycle();
                    sample();
                    if (stall_MEM) n++;
                end
                check("to_drain_len", 32'(n), 32'(MAXW + 1));
                check("to_data", load_data, 32'd0);
                last_data = 32'd0;
                stop = 1'b1;
            end
        end
    endtask

    initial begin
        logic [2:0] f3;
        int delay, lim, fa;
        rst = 1'b1; memRead_EXMEM = 1'b0; Instruction_EXMEM = '0; addr_EXMEM = '0;
        flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        sample();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_stall", 32'(stall_MEM), 32'd0);
        check("rst_valid", 32'(load_valid), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_data", load_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_load(3'd2, 32'h100, 32'hDEADBEEF, 0, -1, 1'b0);
        check("lw_basic", load_data, 32'hDEADBEEF);
        run_load(3'd0, 32'h103, 32'h80112233, 0, -1, 1'b0);
        check("lb_sign", load_data, 32'hFFFFFF80);
        run_load(3'd4, 32'h103, 32'h80112233, 1, -1, 1'b0);
        check("lbu_zero", load_data, 32'h00000080);
        run_load(3'd1, 32'h102, 32'h80112233, 0, -1, 1'b0);
        check("lh_sign", load_data, 32'hFFFF8011);
        run_load(3'd5, 32'h100, 32'h0000F00D, 0, -1, 1'b0);
        check("lhu_zero", load_data, 32'h0000F00D);
        run_load(3'd2, 32'h102, 32'h12345678, 0, -1, 1'b0);
        run_load(3'd2, 32'h200, 32'hCAFEF00D, 5, -1, 1'b0);
        run_load(3'd2, 32'h204, 32'h11111111, 5, 1, 1'b0);
        run_load(3'd2, 32'h208, 32'h22222222, MAXW + 1, -1, 1'b0);
        run_load(3'd2, 32'h20C, 32'h33333333, 0, -1, 1'b1);

        for (int i = 0; i < 80; i++) begin
            f3    = 3'($urandom);
            delay = $urandom_range(0, MAXW + 2);
            fa    = -1;
            lim   = (delay > int'(MAXW)) ? int'(MAXW) : delay - 1;
            if (lim >= 0 && $urandom_range(0, 5) == 0) fa = $urandom_range(0, lim);
            run_load(f3, $urandom, $urandom, delay, fa, $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset while a request is outstanding.
        next_cycle();
        memRead_EXMEM = 1'b1; Instruction_EXMEM = 32'h00002003; addr_EXMEM = 32'h300;
        sample();
        next_cycle();
        sample();
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1; memRead_EXMEM = 1'b0;
        #1;
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_stall", 32'(stall_MEM), 32'd0);
        check("arst_valid", 32'(load_valid), 32'd0);
        check("arst_data", load_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        last_data = 32'd0;
        run_load(3'd2, 32'h400, 32'hA5A5F00F, 2, -1, 1'b0);
        check("post_rst_lw", load_data, 32'hA5A5F00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Load-side data-memory controller for the MEM stage: issues a read request for a load held in EX/MEM, waits for memory, extracts and sign/zero-extends the byte/half/word, and presents the result registered for MEM/WB. Holds the pipeline via `stall_MEM` while a load is outstanding. It is the read counterpart of the store-data forwarding path feeding data memory.

## Interface
- `MAX_WAIT`, 255: cycles spent in REQ before the load is aborted with `load_err`; width of the wait counter is 8 bits.
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `memRead_EXMEM`  in  1  instruction in MEM stage is a load
- `Instruction_EXMEM`  in  32  MEM-stage instruction; funct3 = [14:12] (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW)
- `addr_EXMEM`  in  32  effective byte address from ALU
- `flush`  in  1  squash the MEM-stage instruction
- `mem_req`  out  1  read request to data memory
- `mem_addr`  out  32  word-aligned address (`addr_q & ~3`)
- `mem_rvalid`  in  1  read data valid this cycle
- `mem_rdata`  in  32  read word, little-endian
- `stall_MEM`  out  1  freeze IF..MEM pipeline registers
- `load_valid`  out  1  one-cycle pulse: `load_data` is the result for the load leaving MEM
- `load_data`  out  32  extended load result (registered)
- `load_err`  out  1  one-cycle pulse: misaligned access or timeout

## Operation
- States: IDLE, REQ, DONE, DRAIN. Registers: `addr_q`, `f3_q`, `wait_cnt[7:0]`, `load_data`.
- IDLE: if `memRead_EXMEM && !flush`: misaligned (LH/LHU with addr[0]=1, LW with addr[1:0]!=0) -> pulse `load_err`, `load_data`=0, stay IDLE, no request; else latch addr/funct3, clear `wait_cnt`, -> REQ.
- REQ: `mem_req`=1. `mem_rvalid` -> write extracted data to `load_data`, -> DONE. `flush && !mem_rvalid` -> DRAIN. `wait_cnt`==MAX_WAIT without rvalid -> pulse `load_err`, `load_data`=0, -> DRAIN; else `wait_cnt`++.
- DONE: `load_valid`=1, stall released, -> IDLE unconditionally (the load in EX/MEM this cycle is the completed one; never re-issued).
- DRAIN: `mem_req`=0, wait for `mem_rvalid`, discard data, -> IDLE. Same MAX_WAIT bound; on expiry -> IDLE silently.
- Extraction: byte lane = addr_q[1:0], half lane = addr_q[1]. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passthrough.
- `stall_MEM` = (IDLE && `memRead_EXMEM` && !flush && aligned) || REQ || DRAIN.
- `flush` in DONE: `load_valid` suppressed, -> IDLE.

## Timing
- Reset: state IDLE; `mem_req`=0, `mem_addr`=0, `stall_MEM`=0, `load_valid`=0, `load_err`=0, `load_data`=0, `wait_cnt`=0. Reset mid-REQ abandons the request; memory is reset with the core.
- Load arrives cycle N (stall high same cycle, combinational); `mem_req` high N+1; earliest `mem_rvalid` N+1 -> `load_valid` at N+2, stall low N+2. Minimum load occupancy in MEM: 3 cycles.
- `mem_req` held high from REQ entry until the cycle `mem_rvalid` is sampled; `mem_addr` stable throughout.
- Back-to-back loads: second load is evaluated in IDLE the cycle after DONE; no bubble inserted beyond that.
- `load_err` on misalignment in cycle N (no stall); on timeout at cycle N+1+MAX_WAIT.
- `mem_rvalid` in IDLE/DONE ignored.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, rvalid at N+1 -> `load_valid` at N+2, `load_data`=0xDEADBEEF, stall high N..N+1.
- LB addr 0x103 rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011; LHU addr 0x100 rdata 0x0000F00D -> 0x0000F00D.
- LW addr 0x102 -> `load_err` pulse cycle N, `mem_req` never asserted, `stall_MEM`=0.
- rvalid delayed 5 cycles -> `mem_req` high 6 cycles, stall high through, `load_valid` 1 cycle after rvalid.
- flush while in REQ, rvalid 2 cycles later -> DRAIN, no `load_valid`, `load_data` unchanged, IDLE next; MAX_WAIT=4 with no rvalid -> `load_err` after 4 wait cycles.
- `rst` asserted mid-REQ -> all outputs 0 immediately (async); post-reset LW completes normally.
